// File: rtl/pipe_stage_chain_pkg.sv
// ---------------------------------------------------------------------------
// pipe_stage_chain_pkg
//   Shared helpers for the pipe_stage_chain slice.
//   clog2_f : constant-foldable ceil(log2(n)), never less than 1, so that it
//             is safe for sizing vector ports.
// ---------------------------------------------------------------------------
package pipe_stage_chain_pkg;

    function automatic int clog2_f(input int n);
        int r;
        int v;
        r = 0;
        v = n - 1;
        while (v > 0) begin
            r = r + 1;
            v = v >> 1;
        end
        return (r < 1) ? 1 : r;
    endfunction

endpackage

// File: rtl/pipe_stage_chain_stage.sv
// ---------------------------------------------------------------------------
// pipe_stage
//   One register stage of the chain with valid/ready flow control.
//   Ports:
//     clk, rst_n          clock, async active-low reset
//     flush               synchronous kill: clears valid, keeps data
//     up_valid, up_data   source (previous stage or chain input)
//     dn_ready            ready of the next stage (or chain out_ready)
//     rdy                 this stage can load this cycle (combinational)
//     valid_q, data_q     stage contents
// ---------------------------------------------------------------------------
module pipe_stage
    import pipe_stage_chain_pkg::*;
#(
    parameter int                  DATA_LEN = 32,
    parameter logic [DATA_LEN-1:0] RST_DATA = '0
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                flush,
    input  logic                up_valid,
    input  logic [DATA_LEN-1:0] up_data,
    input  logic                dn_ready,
    output logic                rdy,
    output logic                valid_q,
    output logic [DATA_LEN-1:0] data_q
);

    logic                valid_d;
    logic [DATA_LEN-1:0] data_d;

    // An empty stage is always ready, which is what collapses bubbles.
    assign rdy = !valid_q || dn_ready;

    always_comb begin
        valid_d = valid_q;
        data_d  = data_q;
        if (flush) begin
            valid_d = 1'b0;
        end else if (rdy) begin
            valid_d = up_valid;
            // Only capture real payloads so bubbles do not toggle data.
            if (up_valid) begin
                data_d = up_data;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= 1'b0;
            data_q  <= RST_DATA;
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
        end
    end

endmodule

// File: rtl/pipe_stage_chain.sv
// ---------------------------------------------------------------------------
// pipe_stage_chain
//   DEPTH registered stages with valid/ready on both ends, bubble collapsing,
//   synchronous flush and a registered occupancy count.
//   Ports:
//     clk, rst_n                  clock, async active-low reset
//     flush                       kill all stages at the next edge
//     in_valid, in_ready, in_data upstream handshake
//     out_valid, out_ready, out_data downstream handshake
//     count                       number of valid stages, 0..DEPTH
//   Integration note: out_ready reaches in_ready through a combinational
//   ripple across all DEPTH stages; flush also gates in_ready/out_valid
//   combinationally. There is no in_valid -> out_valid path.
// ---------------------------------------------------------------------------
module pipe_stage_chain
    import pipe_stage_chain_pkg::*;
#(
    parameter int                  DATA_LEN = 32,
    parameter int                  DEPTH    = 2,
    parameter logic [DATA_LEN-1:0] RST_DATA = '0,
    localparam int                 CNT_W    = clog2_f(DEPTH + 1)
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                flush,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [DATA_LEN-1:0] in_data,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [DATA_LEN-1:0] out_data,
    output logic [CNT_W-1:0]    count
);

    // Each stage keeps its handshake signals local to its generate scope so
    // the ready ripple runs through distinct nets rather than one vector.
    for (genvar i = 0; i < DEPTH; i++) begin : stg
        logic                s_up_valid;
        logic [DATA_LEN-1:0] s_up_data;
        logic                s_dn_ready;
        logic                s_rdy;
        logic                s_valid;
        logic [DATA_LEN-1:0] s_data;

        if (i == 0) begin : g_src_in
            assign s_up_valid = in_valid;
            assign s_up_data  = in_data;
        end else begin : g_src_prev
            assign s_up_valid = stg[i-1].s_valid;
            assign s_up_data  = stg[i-1].s_data;
        end

        if (i == DEPTH - 1) begin : g_dn_out
            assign s_dn_ready = out_ready;
        end else begin : g_dn_next
            assign s_dn_ready = stg[i+1].s_rdy;
        end

        pipe_stage #(
            .DATA_LEN (DATA_LEN),
            .RST_DATA (RST_DATA)
        ) u_stage (
            .clk      (clk),
            .rst_n    (rst_n),
            .flush    (flush),
            .up_valid (s_up_valid),
            .up_data  (s_up_data),
            .dn_ready (s_dn_ready),
            .rdy      (s_rdy),
            .valid_q  (s_valid),
            .data_q   (s_data)
        );
    end

    assign in_ready  = stg[0].s_rdy && !flush;
    assign out_valid = stg[DEPTH-1].s_valid && !flush;
    assign out_data  = stg[DEPTH-1].s_data;

    // Occupancy tracked from the two handshakes; this equals the popcount
    // of the stage valids after the edge because beats are never dropped
    // or duplicated outside of flush.
    logic             accept;
    logic             emit;
    logic [CNT_W-1:0] count_d;
    logic [CNT_W-1:0] count_q;

    assign accept = in_valid && in_ready;
    assign emit   = out_valid && out_ready;

    always_comb begin
        count_d = count_q;
        if (flush) begin
            count_d = '0;
        end else if (accept && !emit) begin
            count_d = count_q + 1'b1;
        end else if (!accept && emit) begin
            count_d = count_q - 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;

endmodule

// File: tb/tb_pipe_stage_chain.sv
// Bench for pipe_stage_chain: five instances with DEPTH = 1..5 (instance k
// has DEPTH k+1), directed tables for the multi-cycle corner cases and a
// randomized run against a position-list reference model.
module tb_pipe_stage_chain;

    localparam int NI = 5;
    localparam logic [7:0] RSTV = 8'h5A;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       flush     [NI];
    logic       in_valid  [NI];
    logic       out_ready [NI];
    logic       in_ready  [NI];
    logic       out_valid [NI];
    logic [7:0] in_data   [NI];
    logic [7:0] out_data  [NI];
    logic [3:0] cnt       [NI];

    always #5 clk = ~clk;

    for (genvar g = 0; g < NI; g++) begin : dut
        localparam int D = g + 1;
        logic [$clog2(D+1)-1:0] c;
        pipe_stage_chain #(
            .DATA_LEN (8),
            .DEPTH    (D),
            .RST_DATA (RSTV)
        ) u_dut (
            .clk       (clk),
            .rst_n     (rst_n),
            .flush     (flush[g]),
            .in_valid  (in_valid[g]),
            .in_ready  (in_ready[g]),
            .in_data   (in_data[g]),
            .out_valid (out_valid[g]),
            .out_ready (out_ready[g]),
            .out_data  (out_data[g]),
            .count     (c)
        );
        assign cnt[g] = 4'(c);
    end

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    typedef struct {
        logic       iv;
        logic [7:0] d;
        logic       ordy;
        logic       fl;
        logic       e_ir;
        logic       e_ov;
        logic [7:0] e_od;
        int         e_cnt;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(logic iv, logic [7:0] d, logic ordy, logic fl,
                                logic eir, logic eov, logic [7:0] eod, int ecnt);
        vec_t v;
        v.iv = iv; v.d = d; v.ordy = ordy; v.fl = fl;
        v.e_ir = eir; v.e_ov = eov; v.e_od = eod; v.e_cnt = ecnt;
        return v;
    endfunction

    task automatic idle_all();
        for (int k = 0; k < NI; k++) begin
            flush[k] = 1'b0; in_valid[k] = 1'b0; out_ready[k] = 1'b0; in_data[k] = 8'h00;
        end
    endtask

    // Drive one row after the rising edge, check at the falling edge.
    task automatic run_tbl(input int k, input string tag);
        for (int r = 0; r < tbl.size(); r++) begin
            @(posedge clk); #1;
            in_valid[k]  = tbl[r].iv;
            in_data[k]   = tbl[r].d;
            out_ready[k] = tbl[r].ordy;
            flush[k]     = tbl[r].fl;
            @(negedge clk);
            chk($sformatf("%s[%0d] in_ready", tag, r), 32'(in_ready[k]), 32'(tbl[r].e_ir));
            chk($sformatf("%s[%0d] out_valid", tag, r), 32'(out_valid[k]), 32'(tbl[r].e_ov));
            chk($sformatf("%s[%0d] count", tag, r), 32'(cnt[k]), 32'(tbl[r].e_cnt));
            if (tbl[r].e_ov)
                chk($sformatf("%s[%0d] out_data", tag, r), 32'(out_data[k]), 32'(tbl[r].e_od));
        end
        @(posedge clk); #1;
        idle_all();
        tbl.delete();
    endtask

    // Reference model: ordered list of beats (oldest first) with the stage
    // index each currently sits in. A beat advances one stage per cycle
    // unless the slot ahead is still occupied after the cycle.
    logic [7:0] md [NI][8];
    int         mp [NI][8];
    int         mn [NI];

    initial begin
        rst_n = 1'b0;
        idle_all();
        for (int k = 0; k < NI; k++) mn[k] = 0;

        // Reset state
        #12;
        for (int k = 0; k < NI; k++) begin
            chk($sformatf("rst%0d out_valid", k), 32'(out_valid[k]), 32'd0);
            chk($sformatf("rst%0d in_ready", k), 32'(in_ready[k]), 32'd1);
            chk($sformatf("rst%0d out_data", k), 32'(out_data[k]), 32'(RSTV));
            chk($sformatf("rst%0d count", k), 32'(cnt[k]), 32'd0);
        end
        @(negedge clk); rst_n = 1'b1;

        // Streaming, DEPTH=3
        tbl.push_back(mk(1, 8'h01, 1, 0, 1, 0, 8'h00, 0));
        tbl.push_back(mk(1, 8'h02, 1, 0, 1, 0, 8'h00, 1));
        tbl.push_back(mk(1, 8'h03, 1, 0, 1, 0, 8'h00, 2));
        for (int i = 0; i < 5; i++)
            tbl.push_back(mk(1, 8'(i + 4), 1, 0, 1, 1, 8'(i + 1), 3));
        tbl.push_back(mk(0, 8'h00, 1, 0, 1, 1, 8'h06, 3));
        tbl.push_back(mk(0, 8'h00, 1, 0, 1, 1, 8'h07, 2));
        tbl.push_back(mk(0, 8'h00, 1, 0, 1, 1, 8'h08, 1));
        tbl.push_back(mk(0, 8'h00, 1, 0, 1, 0, 8'h00, 0));
        run_tbl(2, "stream");

        // Backpressure, DEPTH=2
        tbl.push_back(mk(1, 8'h0A, 0, 0, 1, 0, 8'h00, 0));
        tbl.push_back(mk(1, 8'h0B, 0, 0, 1, 0, 8'h00, 1));
        tbl.push_back(mk(1, 8'h0C, 0, 0, 0, 1, 8'h0A, 2));
        tbl.push_back(mk(1, 8'h0C, 0, 0, 0, 1, 8'h0A, 2));
        tbl.push_back(mk(1, 8'h0C, 1, 0, 1, 1, 8'h0A, 2));
        tbl.push_back(mk(0, 8'h00, 1, 0, 1, 1, 8'h0B, 2));
        tbl.push_back(mk(0, 8'h00, 1, 0, 1, 1, 8'h0C, 1));
        tbl.push_back(mk(0, 8'h00, 1, 0, 1, 0, 8'h00, 0));
        run_tbl(1, "bp");

        // Bubble collapse, DEPTH=4
        tbl.push_back(mk(1, 8'h11, 0, 0, 1, 0, 8'h00, 0));
        tbl.push_back(mk(0, 8'h00, 0, 0, 1, 0, 8'h00, 1));
        tbl.push_back(mk(0, 8'h00, 0, 0, 1, 0, 8'h00, 1));
        tbl.push_back(mk(0, 8'h00, 0, 0, 1, 0, 8'h00, 1));
        tbl.push_back(mk(1, 8'h22, 0, 0, 1, 1, 8'h11, 1));
        tbl.push_back(mk(1, 8'h33, 0, 0, 1, 1, 8'h11, 2));
        tbl.push_back(mk(1, 8'h44, 0, 0, 1, 1, 8'h11, 3));
        tbl.push_back(mk(0, 8'h00, 0, 0, 0, 1, 8'h11, 4));
        tbl.push_back(mk(1, 8'h55, 0, 0, 0, 1, 8'h11, 4));
        tbl.push_back(mk(0, 8'h00, 1, 0, 1, 1, 8'h11, 4));
        tbl.push_back(mk(0, 8'h00, 1, 0, 1, 1, 8'h22, 3));
        tbl.push_back(mk(0, 8'h00, 1, 0, 1, 1, 8'h33, 2));
        tbl.push_back(mk(0, 8'h00, 1, 0, 1, 1, 8'h44, 1));
        tbl.push_back(mk(0, 8'h00, 1, 0, 1, 0, 8'h00, 0));
        run_tbl(3, "bubble");

        // Flush on a full DEPTH=3 chain
        tbl.push_back(mk(1, 8'h91, 0, 0, 1, 0, 8'h00, 0));
        tbl.push_back(mk(1, 8'h92, 0, 0, 1, 0, 8'h00, 1));
        tbl.push_back(mk(1, 8'h93, 0, 0, 1, 0, 8'h00, 2));
        tbl.push_back(mk(1, 8'h94, 1, 1, 0, 0, 8'h00, 3));
        tbl.push_back(mk(1, 8'h95, 1, 0, 1, 0, 8'h00, 0));
        tbl.push_back(mk(0, 8'h00, 1, 0, 1, 0, 8'h00, 1));
        tbl.push_back(mk(0, 8'h00, 1, 0, 1, 0, 8'h00, 1));
        tbl.push_back(mk(0, 8'h00, 1, 0, 1, 1, 8'h95, 1));
        tbl.push_back(mk(0, 8'h00, 1, 0, 1, 0, 8'h00, 0));
        run_tbl(2, "flush");

        // Asynchronous reset mid-stream, DEPTH=3
        in_valid[2] = 1'b1; in_data[2] = 8'h77; out_ready[2] = 1'b0;
        repeat (3) @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("arst out_valid", 32'(out_valid[2]), 32'd0);
        chk("arst out_data", 32'(out_data[2]), 32'(RSTV));
        chk("arst count", 32'(cnt[2]), 32'd0);
        chk("arst in_ready", 32'(in_ready[2]), 32'd1);
        idle_all();
        @(negedge clk); @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("arst-rel out_valid", 32'(out_valid[2]), 32'd0);
        chk("arst-rel count", 32'(cnt[2]), 32'd0);

        // Randomized run against the reference model, all depths at once
        for (int cyc = 0; cyc < 10000; cyc++) begin
            @(posedge clk); #1;
            for (int k = 0; k < NI; k++) begin
                in_valid[k]  = ($urandom_range(0, 9) < 7);
                out_ready[k] = ($urandom_range(0, 9) < 6);
                flush[k]     = ($urandom_range(0, 99) < 2);
                in_data[k]   = 8'($urandom);
            end
            @(negedge clk);
            for (int k = 0; k < NI; k++) begin
                int  d;
                int  lim;
                int  pop;
                int  nn;
                logic head;
                logic e_ir;
                logic [7:0] nd [8];
                int         np [8];
                d    = k + 1;
                head = (mn[k] > 0) && (mp[k][0] == d - 1);
                pop  = (head && out_ready[k] && !flush[k]) ? 1 : 0;
                lim  = d - 1;
                nn   = 0;
                for (int j = pop; j < mn[k]; j++) begin
                    int p;
                    p = (mp[k][j] + 1 < lim) ? mp[k][j] + 1 : lim;
                    nd[nn] = md[k][j];
                    np[nn] = p;
                    nn++;
                    lim = p - 1;
                end
                e_ir = !flush[k] && (lim >= 0);

                chk($sformatf("rnd d%0d out_valid", d), 32'(out_valid[k]), 32'(head && !flush[k]));
                chk($sformatf("rnd d%0d in_ready", d), 32'(in_ready[k]), 32'(e_ir));
                chk($sformatf("rnd d%0d count", d), 32'(cnt[k]), 32'(mn[k]));
                if (head && !flush[k])
                    chk($sformatf("rnd d%0d out_data", d), 32'(out_data[k]), 32'(md[k][0]));

                if (flush[k]) begin
                    mn[k] = 0;
                end else begin
                    if (in_valid[k] && e_ir) begin
                        nd[nn] = in_data[k];
                        np[nn] = 0;
                        nn++;
                    end
                    for (int j = 0; j < nn; j++) begin
                        md[k][j] = nd[j];
                        mp[k][j] = np[j];
                    end
                    mn[k] = nn;
                end
            end
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
